// File: rtl/window_pkg.sv
// window_pkg: shared pixel/window types and FSM state enum for window_3x3_linebuf
package window_pkg;
  localparam int PIXEL_W_DEF = 4;
  typedef logic [PIXEL_W_DEF-1:0] pixel_t;
  typedef pixel_t window_t [2:0][2:0];
  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} win_state_e;
endpackage

// File: rtl/window_3x3_linebuf_if.sv
// window_3x3_linebuf_if: pixel stream in (in_pixel/in_valid/in_sof), 3x3 window out (out_window/out_valid)
interface window_3x3_linebuf_if #(parameter int PIXEL_W = window_pkg::PIXEL_W_DEF);
  logic [PIXEL_W-1:0] in_pixel;
  logic in_valid;
  logic in_sof;
  logic [PIXEL_W-1:0] out_window [2:0][2:0];
  logic out_valid;
  modport master (output in_pixel, in_valid, in_sof, input out_window, out_valid);
  modport slave (input in_pixel, in_valid, in_sof, output out_window, out_valid);
endinterface

// File: rtl/line_delay.sv
// line_delay: circular-pointer RAM delaying din by DEPTH enabled cycles; ports clk, en, din, dout
module line_delay #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 640
) (
  input  logic             clk,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] ptr_q, ptr_d;
  always_comb ptr_d = !en ? ptr_q : ptr_q == AW'(DEPTH - 1) ? '0 : ptr_q + 1'b1;
  // read-before-write at the same slot: dout is the sample written DEPTH enables ago
  assign dout = mem[ptr_q];
  always_ff @(posedge clk) begin
    if (en) mem[ptr_q] <= din;
    ptr_q <= ptr_d;
  end
endmodule

// File: rtl/window_3x3_linebuf.sv
// window_3x3_linebuf: raster stream to registered 3x3 windows; ports clk, reset (async, active-high), bus (slave), WIN_STATS_EN adds frame_done/win_cnt
module window_3x3_linebuf
  import window_pkg::*;
#(
  parameter int PIXEL_W = PIXEL_W_DEF,
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480
) (
  input  logic clk,
  input  logic reset,
  window_3x3_linebuf_if.slave bus
`ifdef WIN_STATS_EN
  ,
  output logic        frame_done,
  output logic [31:0] win_cnt
`endif
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  win_state_e state_q, state_d;
  logic [CW-1:0] col_q, col_d, col_c;
  logic [RW-1:0] row_q, row_d, row_c;
  logic sof, take, wrap, last, win;
  logic out_valid_q, out_valid_d;
  logic [PIXEL_W-1:0] ld0_dout, ld1_dout;
  logic [PIXEL_W-1:0] feed [2:0];
  logic [PIXEL_W-1:0] win_q [2:0][2:0];
  logic [PIXEL_W-1:0] win_d [2:0][2:0];
  line_delay #(.WIDTH(PIXEL_W), .DEPTH(IMG_W)) u_ld1 (.clk(clk), .en(take), .din(bus.in_pixel), .dout(ld1_dout));
  line_delay #(.WIDTH(PIXEL_W), .DEPTH(IMG_W)) u_ld0 (.clk(clk), .en(take), .din(ld1_dout), .dout(ld0_dout));
  always_comb begin
    sof = bus.in_valid && bus.in_sof;
    // pixels outside a frame (IDLE/DONE without sof) are dropped and shift nothing
    take = sof || (bus.in_valid && (state_q == FILL || state_q == RUN));
    // an sof pixel is always position (0,0), even when it aborts a frame
    col_c = sof ? '0 : col_q;
    row_c = sof ? '0 : row_q;
    wrap = col_c == CW'(IMG_W - 1);
    last = wrap && row_c == RW'(IMG_H - 1);
    win = take && row_c >= RW'(2) && col_c >= CW'(2);
    col_d = !take ? col_q : wrap ? '0 : col_c + 1'b1;
    row_d = !take ? row_q : wrap ? row_c + 1'b1 : row_c;
    state_d = sof ? FILL
            : (state_q == FILL && take && row_c == RW'(2) && col_c == '0) ? RUN
            : (state_q == RUN && take && last) ? DONE
            : state_q == DONE ? IDLE : state_q;
    out_valid_d = win;
    feed[0] = ld0_dout;
    feed[1] = ld1_dout;
    feed[2] = bus.in_pixel;
    for (int i = 0; i < 3; i++) begin
      win_d[i][0] = take ? win_q[i][1] : win_q[i][0];
      win_d[i][1] = take ? win_q[i][2] : win_q[i][1];
      win_d[i][2] = take ? feed[i] : win_q[i][2];
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      win_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      win_q       <= win_d;
    end
  end
  assign bus.out_window = win_q;
  assign bus.out_valid  = out_valid_q;
`ifdef WIN_STATS_EN
  logic [31:0] win_cnt_q, win_cnt_d;
  always_comb win_cnt_d = sof ? '0 : win ? win_cnt_q + 32'd1 : win_cnt_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) win_cnt_q <= '0;
    else win_cnt_q <= win_cnt_d;
  end
  assign frame_done = state_q == DONE;
  assign win_cnt    = win_cnt_q;
`endif
endmodule

// File: doc/window_3x3_linebuf.md
# window_3x3_linebuf

Streaming 3x3 window generator that sits directly upstream of `de_noise_activation`. It accepts one raster-order pixel per valid cycle and buffers two image lines. For every interior pixel position it presents a registered 3x3 neighbourhood on `out_window`, the exact array shape `de_noise_activation.in` consumes.

## Interface
- `PIXEL_W`, 4: pixel width in bits.
- `IMG_W`, 640: pixels per line; must be ≥3.
- `IMG_H`, 480: lines per frame; must be ≥3.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-high reset.
- `in_pixel`  input  PIXEL_W  raster-order pixel.
- `in_valid`  input  1  pixel accepted this cycle; there is no backpressure.
- `in_sof`  input  1  qualifies `in_valid`; marks pixel (0,0) of a frame.
- `out_window`  output  [2:0][2:0] x PIXEL_W  unpacked window; `[i][j]` is row i (0 = oldest) and column j (0 = leftmost).
- `out_valid`  output  1  one-cycle pulse when a new window is presented.
- `frame_done`  output  1  present only with `WIN_STATS_EN`; see Configuration.
- `win_cnt`  output  32  present only with `WIN_STATS_EN`; see Configuration.

## Operation
- The FSM has four states: IDLE, FILL, RUN and DONE.
  - IDLE: accepted pixels without `in_sof` are dropped.
  - Accepted pixel with `in_sof` → FILL. That pixel is processed as (0,0).
  - FILL (rows 0–1) → RUN on acceptance of pixel (2,0).
  - RUN → DONE on acceptance of pixel (IMG_H-1, IMG_W-1).
  - DONE → IDLE after 1 cycle.
- Row and column counters advance only on accepted pixels. The column wraps from IMG_W-1 to 0, and the row counter increments on that wrap.
- `in_sof` on an accepted pixel in FILL, RUN or DONE aborts the frame. Counters restart at (0,0) and the FSM enters FILL; no window is emitted for the aborted position.
- Two line delays of IMG_W accepted pixels are chained. Line delay 1 takes `in_pixel` and yields pixel (r-1,c). Line delay 0 takes the output of line delay 1 and yields pixel (r-2,c).
- Three 3-tap row shift registers sit behind the line delays:
  - row 2 is fed by `in_pixel`;
  - row 1 is fed by line delay 1;
  - row 0 is fed by line delay 0.
  - Each shifts only on accepted pixels, with the new pixel entering column 2.
- The window is valid when accepted pixel (r,c) has r≥2 and c≥2. Then `out_window[i][j]` = pixel(r-2+i, c-2+j), centred on (r-1, c-1).
- Exactly (IMG_W-2)·(IMG_H-2) windows are emitted per complete frame.
- `out_window` holds its value between accepted pixels. Its contents are don't-care when the preceding `out_valid` was not asserted.
- No arithmetic is performed on pixel data. Counter widths are $clog2(IMG_W) and $clog2(IMG_H).

## Timing
- Latency is 1 cycle: `out_valid` and the updated `out_window` appear in the cycle after the pixel that completes the window is accepted.
- Gaps in `in_valid` are allowed. During a gap, `out_valid` is 0 and nothing shifts.
- Back-to-back pixels give back-to-back `out_valid` pulses within a line.
- Reset values:
  - `out_valid`, `out_window`, `frame_done`, `win_cnt`, counters: 0.
  - FSM: IDLE.
  - Line delay contents are not reset.
- Reset asserted mid-frame clears outputs immediately (asynchronously). The next frame needs `in_sof`.

## Configuration
- Macro: `WIN_STATS_EN`.
- Defined:
  - `frame_done` pulses for 1 cycle in DONE.
  - `win_cnt` counts the windows emitted in the current frame. It clears on an accepted `in_sof` and holds its value after DONE until the next `in_sof`.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

## Structure
- Package `window_pkg` holds:
  - `PIXEL_W_DEF`;
  - `pixel_t`;
  - `window_t` (unpacked [2:0][2:0] of `pixel_t`);
  - the FSM state enum `win_state_e`.
- Sub-module `line_delay` (parameters WIDTH, DEPTH; ports `clk`, `en`, `din`, `dout`) is a circular-pointer RAM delay of DEPTH enabled cycles. It is instantiated twice.

## Test plan
All scenarios use IMG_W=5, IMG_H=4, PIXEL_W=4, and value of pixel (r,c) = (5r+c) mod 16.
- Reset check: assert `reset` with no clock edge → all outputs read 0 and the FSM is in IDLE.
- Ramp frame with continuous `in_valid`:
  - first `out_valid` is 1 cycle after pixel 12 is accepted, with `[0][0]`=0, `[1][1]`=6, `[2][2]`=4'hC;
  - 6 pulses in total;
  - last window has `[2][2]`=3 (pixel 19).
- Same frame with `in_valid` asserted every other cycle → identical 6 windows, each pulse 1 cycle after its accepting edge.
- Pixels sent without `in_sof`, then `in_sof` asserted at pixel 8 of frame A → no output for frame A.
  - The new frame produces its first window after its own pixel 12.
- Reset pulse in the cycle after pixel 13 → `out_valid` drops immediately, and no windows appear until the next `in_sof`.
- With `WIN_STATS_EN` and a ramp frame:
  - `frame_done` is high for exactly 1 cycle, 1 cycle after pixel 19 is accepted;
  - `win_cnt`=6 and holds until the next `in_sof`.
